// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel period timer.
package timer_pkg;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_DONE
  } timer_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counts 0..period-1 in periodic or one-shot mode.
// Counting and wrap only advance on strobe cycles; config change, period==0
// and start act on any cycle.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [WIDTH-1:0] period,
  input  logic             mode,
  input  logic             enable,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic [WIDTH:0]   inc;
  logic             wrap;
  logic             cfg_change;

  // wrap is evaluated one bit wider so period = 2^WIDTH-1 never overflows
  assign inc        = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
  assign wrap       = (inc == {1'b0, period});
  assign cfg_change = (period != period_q) || (mode != mode_q);

  // State, count, tick and stored configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T_IDLE;
      count_q  <= '0;
      tick_q   <= 1'b0;
      period_q <= '0;
      mode_q   <= MODE_PERIODIC;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
      period_q <= period;
      mode_q   <= mode;
    end
  end

  // Next-state and next-count decode in priority order
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    if (cfg_change) begin
      count_d = '0;
      state_d = T_IDLE;
    end else if (period == '0) begin
      count_d = '0;
      state_d = T_IDLE;
    end else if (mode == MODE_PERIODIC) begin
      if (start) begin
        count_d = '0;
      end else if (enable && strobe) begin
        if (wrap) begin
          count_d = '0;
          tick_d  = 1'b1;
        end else begin
          count_d = inc[WIDTH-1:0];
        end
      end
    end else begin
      unique case (state_q)
        T_IDLE, T_DONE: begin
          count_d = '0;
          if (start) state_d = T_RUN;
        end
        T_RUN: begin
          if (start) begin
            count_d = '0;
          end else if (enable && strobe) begin
            if (wrap) begin
              count_d = '0;
              tick_d  = 1'b1;
              state_d = T_DONE;
            end else begin
              count_d = inc[WIDTH-1:0];
            end
          end
        end
        default: begin
          count_d = '0;
          state_d = T_IDLE;
        end
      endcase
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign busy  = (state_q == T_RUN);

endmodule

// File: rtl/multi_period_timer.sv
// Multi-channel period timer: NUM_CH independent timer_channel instances
// sharing one count strobe.
// Optional macro MULTI_PERIOD_TIMER_PRESCALE_EN: the strobe comes from a
// shared 0..PRESCALE-1 prescaler; otherwise the strobe is constant 1.
module multi_period_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRESCALE = 100
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_CH*WIDTH-1:0] period_in,
  input  logic [NUM_CH-1:0]       mode_in,
  input  logic [NUM_CH-1:0]       enable_in,
  input  logic [NUM_CH-1:0]       start_in,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       tick_out,
  output logic [NUM_CH-1:0]       busy_out
);

  logic strobe;

  if (NUM_CH < 1 || NUM_CH > 16 || PRESCALE < 1) begin : g_bad_param
    $error("multi_period_timer: NUM_CH must be 1..16 and PRESCALE >= 1");
  end

`ifdef MULTI_PERIOD_TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;

  assign strobe = (pre_cnt == PW'(PRESCALE - 1));

  // Shared prescaler, wraps to 0 on each strobe
  always_ff @(posedge clk_in) begin
    if (rst_in || strobe) pre_cnt <= '0;
    else                  pre_cnt <= pre_cnt + 1'b1;
  end
`else
  assign strobe = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk   (clk_in),
      .rst   (rst_in),
      .strobe(strobe),
      .period(period_in[i*WIDTH +: WIDTH]),
      .mode  (mode_in[i]),
      .enable(enable_in[i]),
      .start (start_in[i]),
      .count (count_out[i*WIDTH +: WIDTH]),
      .tick  (tick_out[i]),
      .busy  (busy_out[i])
    );
  end

endmodule

// File: tb/tb_multi_period_timer.sv
// Directed-vector bench for multi_period_timer (NUM_CH=2, WIDTH=4, PRESCALE=3).
module tb_multi_period_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] period = '0;
  logic [1:0] mode = '0;
  logic [1:0] enable = '0;
  logic [1:0] start = '0;
  logic [7:0] count;
  logic [1:0] tick;
  logic [1:0] busy;

  int unsigned applied = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic       rst;
    logic [3:0] p0, p1;
    logic [1:0] mode, en, st;
    logic [3:0] c0, c1;
    logic [1:0] tick, busy;
  } vec_t;

  vec_t vecs[$];

  multi_period_timer #(
    .NUM_CH  (2),
    .WIDTH   (4),
    .PRESCALE(3)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .period_in(period),
    .mode_in  (mode),
    .enable_in(enable),
    .start_in (start),
    .count_out(count),
    .tick_out (tick),
    .busy_out (busy)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [3:0] p0, input logic [3:0] p1,
                              input logic [1:0] m, input logic [1:0] en, input logic [1:0] st,
                              input logic [3:0] c0, input logic [3:0] c1,
                              input logic [1:0] t, input logic [1:0] b);
    vec_t v;
    v.rst = r; v.p0 = p0; v.p1 = p1; v.mode = m; v.en = en; v.st = st;
    v.c0 = c0; v.c1 = c1; v.tick = t; v.busy = b;
    vecs.push_back(v);
  endfunction

  // ch0 periodic, ch1 disabled (period 0)
  function automatic void per(input logic [3:0] p0, input logic [3:0] c0, input logic t0);
    add(1'b0, p0, 4'd0, 2'b00, 2'b11, 2'b00, c0, 4'd0, {1'b0, t0}, 2'b00);
  endfunction

  // ch0 one-shot with period 4, ch1 disabled
  function automatic void os(input logic en0, input logic st0, input logic [3:0] c0,
                             input logic t0, input logic b0);
    add(1'b0, 4'd4, 4'd0, 2'b01, {1'b1, en0}, {1'b0, st0}, c0, 4'd0, {1'b0, t0}, {1'b0, b0});
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [11:0] got, want;
    rst    = v.rst;
    period = {v.p1, v.p0};
    mode   = v.mode;
    enable = v.en;
    start  = v.st;
    @(posedge clk);
    #1;
    got  = {count, tick, busy};
    want = {v.c1, v.c0, v.tick, v.busy};
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got count=%h tick=%b busy=%b, expected count=%h tick=%b busy=%b",
               name, count, tick, busy, {v.c1, v.c0}, v.tick, v.busy);
    end
  endtask

  initial begin
    vec_t h;

    add(1'b1, 4'd5, 4'd0, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00);
    add(1'b1, 4'd5, 4'd0, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00);

`ifdef MULTI_PERIOD_TIMER_PRESCALE_EN
    // prescale 3, period 2: advance every 3rd cycle, tick every 6
    per(2, 0, 0); per(2, 0, 0); per(2, 1, 0); per(2, 1, 0); per(2, 1, 0); per(2, 0, 1);
    per(2, 0, 0); per(2, 0, 0); per(2, 1, 0); per(2, 1, 0); per(2, 1, 0); per(2, 0, 1);
`else
    // periodic, period 5 (first cycle is a config change from stored 0)
    per(5, 0, 0); per(5, 1, 0); per(5, 2, 0); per(5, 3, 0); per(5, 4, 0); per(5, 0, 1);
    per(5, 1, 0); per(5, 2, 0); per(5, 3, 0); per(5, 4, 0); per(5, 0, 1); per(5, 1, 0);
    // period 10 up to count 7, then shrink to 3
    per(10, 0, 0);
    for (int i = 1; i <= 7; i++) per(10, 4'(i), 0);
    per(3, 0, 0); per(3, 1, 0); per(3, 2, 0); per(3, 0, 1); per(3, 1, 0);
    // start resync, then enable-low hold
    add(1'b0, 4'd3, 4'd0, 2'b00, 2'b11, 2'b01, 4'd0, 4'd0, 2'b00, 2'b00);
    per(3, 1, 0);
    add(1'b0, 4'd3, 4'd0, 2'b00, 2'b10, 2'b00, 4'd1, 4'd0, 2'b00, 2'b00);
    add(1'b0, 4'd3, 4'd0, 2'b00, 2'b10, 2'b00, 4'd1, 4'd0, 2'b00, 2'b00);
    per(3, 2, 0); per(3, 0, 1);
    // period 1: tick every enabled cycle
    per(1, 0, 0); per(1, 0, 1); per(1, 0, 1); per(1, 0, 1);
    // ch0 period 2, ch1 period 0 with mode change and start pulses
    per(2, 0, 0);
    add(1'b0, 4'd2, 4'd0, 2'b10, 2'b11, 2'b10, 4'd1, 4'd0, 2'b00, 2'b00);
    add(1'b0, 4'd2, 4'd0, 2'b10, 2'b11, 2'b10, 4'd0, 4'd0, 2'b01, 2'b00);
    per(2, 1, 0);
    // reset mid-run, then restart
    add(1'b1, 4'd2, 4'd0, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00);
    per(2, 0, 0); per(2, 1, 0); per(2, 0, 1);
    // ch1 periodic 3 with ch0 disabled
    add(1'b0, 4'd0, 4'd3, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00);
    add(1'b0, 4'd0, 4'd3, 2'b00, 2'b11, 2'b00, 4'd0, 4'd1, 2'b00, 2'b00);
    add(1'b0, 4'd0, 4'd3, 2'b00, 2'b11, 2'b00, 4'd0, 4'd2, 2'b00, 2'b00);
    add(1'b0, 4'd0, 4'd3, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 2'b10, 2'b00);
    // one-shot period 4: idle ignores enable, single tick, done holds 0
    os(1, 0, 0, 0, 0); os(1, 0, 0, 0, 0);
    os(1, 1, 0, 0, 1); os(1, 0, 1, 0, 1); os(1, 0, 2, 0, 1); os(1, 0, 3, 0, 1);
    os(1, 0, 0, 1, 0); os(1, 0, 0, 0, 0); os(1, 0, 0, 0, 0); os(1, 0, 0, 0, 0);
    // retrigger at count 2
    os(1, 1, 0, 0, 1); os(1, 0, 1, 0, 1); os(1, 0, 2, 0, 1);
    os(1, 1, 0, 0, 1); os(1, 0, 1, 0, 1); os(1, 0, 2, 0, 1); os(1, 0, 3, 0, 1);
    os(1, 0, 0, 1, 0);
    // enable low for 3 cycles in RUN
    os(1, 1, 0, 0, 1); os(1, 0, 1, 0, 1);
    os(0, 0, 1, 0, 1); os(0, 0, 1, 0, 1); os(0, 0, 1, 0, 1);
    os(1, 0, 2, 0, 1); os(1, 0, 3, 0, 1); os(1, 0, 0, 1, 0); os(1, 0, 0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

`ifndef MULTI_PERIOD_TIMER_PRESCALE_EN
    // maximum period 15 in 4 bits: counts to 14, wraps without overflow
    h.rst = 1'b0; h.p0 = 4'd15; h.p1 = 4'd0; h.mode = 2'b00; h.en = 2'b11; h.st = 2'b00;
    h.c1 = 4'd0; h.busy = 2'b00; h.tick = 2'b00; h.c0 = 4'd0;
    apply(h, "max_cfg");
    for (int i = 1; i <= 14; i++) begin
      h.c0 = 4'(i);
      apply(h, $sformatf("max_cnt%0d", i));
    end
    h.c0 = 4'd0; h.tick = 2'b01;
    apply(h, "max_wrap");
    h.c0 = 4'd1; h.tick = 2'b00;
    apply(h, "max_after");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
